mod20_step_sequencer: RTL and testbench

// - Command-driven sequencer for the mod-20 counter. It drives the counter's S0/S1 mode pins.
// - Accepts step commands (hold / up / down / clear, N steps) over a valid/ready handshake.
// - Issues one-cycle mode pulses, paced by an internal prescaler tick.
// - Keeps a shadow copy of the expected counter value.
// - Sits between the control logic and the counter, which runs on the 50 MHz clock.

---
 rtl/mod20_step_sequencer_if.sv | 13 +
 rtl/mod20_step_sequencer.sv | 128 ++++++++++++
 tb/tb_mod20_step_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod20_step_sequencer_if.sv
// Command channel into the mod-20 step sequencer: valid/ready handshake
// carrying a step mode and a step count.
interface mod20_step_sequencer_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [LEN_W-1:0] cmd_len;

  modport master (output cmd_valid, cmd_mode, cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, cmd_mode, cmd_len, output cmd_ready);
endinterface

// File: rtl/mod20_step_sequencer.sv
// Command-driven sequencer for the mod-20 counter: turns queued step commands
// into tick-paced one-cycle S1/S0 pulses and tracks the expected counter value.
//
// state | meaning
// IDLE  | no command loaded
// RUN   | active command issuing its steps
// FIN   | one-cycle completion (done), then next command or IDLE
module mod20_step_sequencer #(
  parameter int DIV   = 50,
  parameter int LEN_W = 8
) (
  input  logic                  clk_50M,
  input  logic                  reset,
  mod20_step_sequencer_if.slave cmd,
  output logic                  S0,
  output logic                  S1,
  output logic                  busy,
  output logic                  done,
  output logic [4:0]            pos
);

  localparam int              PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);
  localparam logic [1:0]      M_UP       = 2'd1;
  localparam logic [1:0]      M_DOWN     = 2'd2;
  localparam logic [1:0]      M_CLEAR    = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    presc;
  logic             tick;
  logic [1:0]       act_mode;
  logic [LEN_W-1:0] act_rem;
  logic             pend_valid;
  logic [1:0]       pend_mode;
  logic [LEN_W-1:0] pend_len;
  logic             pulse;
  logic [1:0]       s_q;
  logic [4:0]       pos_q;

  logic accept, load_slot, take_pend, take_cmd, push_pend, step;

  // CLEAR is a single step regardless of the requested length.
  function automatic logic [LEN_W-1:0] step_count(input logic [1:0] m, input logic [LEN_W-1:0] l);
    return (m == M_CLEAR) ? LEN_W'(1) : l;
  endfunction

  assign tick      = (presc == PRESC_LAST);
  assign accept    = cmd.cmd_valid & ~pend_valid;
  assign load_slot = (state != ST_RUN);
  assign take_pend = load_slot & pend_valid;
  assign take_cmd  = load_slot & ~pend_valid & accept;
  assign push_pend = accept & ~take_cmd;
  assign step      = (state == ST_RUN) & tick & (|act_rem);

  always_ff @(posedge clk_50M) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pend_valid | accept) state_nxt = ST_RUN;
      ST_RUN:  if (~(|act_rem) & ~pulse) state_nxt = ST_FIN;
      ST_FIN:  state_nxt = (pend_valid | accept) ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state == ST_RUN);
    done          = (state == ST_FIN);
    cmd.cmd_ready = ~pend_valid;
    S0            = s_q[0];
    S1            = s_q[1];
    pos           = pos_q;
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      presc      <= '0;
      act_mode   <= 2'd0;
      act_rem    <= '0;
      pend_valid <= 1'b0;
      pend_mode  <= 2'd0;
      pend_len   <= '0;
      pulse      <= 1'b0;
      s_q        <= 2'b00;
      pos_q      <= 5'd0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;

      if (push_pend) begin
        pend_valid <= 1'b1;
        pend_mode  <= cmd.cmd_mode;
        pend_len   <= cmd.cmd_len;
      end else if (take_pend) begin
        pend_valid <= 1'b0;
      end

      if (take_pend) begin
        act_mode <= pend_mode;
        act_rem  <= step_count(pend_mode, pend_len);
      end else if (take_cmd) begin
        act_mode <= cmd.cmd_mode;
        act_rem  <= step_count(cmd.cmd_mode, cmd.cmd_len);
      end else if (step) begin
        act_rem <= act_rem - LEN_W'(1);
      end

      // HOLD steps still occupy a pulse slot but drive 00 on the pins.
      pulse <= step;
      s_q   <= step ? act_mode : 2'b00;

      if (pulse) begin
        case (act_mode)
          M_UP:    pos_q <= (pos_q == 5'd19) ? 5'd0 : pos_q + 5'd1;
          M_DOWN:  pos_q <= (pos_q == 5'd0) ? 5'd19 : pos_q - 5'd1;
          M_CLEAR: pos_q <= 5'd0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mod20_step_sequencer.sv
// Bench for mod20_step_sequencer: directed scenarios plus random command
// streams checked against a transaction-level model of queued commands.
module tb_mod20_step_sequencer;
  localparam int         DIV   = 4;
  localparam int         LEN_W = 8;
  localparam logic [1:0] HOLD  = 2'd0;
  localparam logic [1:0] UP    = 2'd1;
  localparam logic [1:0] DOWN  = 2'd2;
  localparam logic [1:0] CLEAR = 2'd3;

  typedef struct {
    logic [1:0] mode;
    int         len;
  } cmd_t;

  logic clk = 1'b0;
  logic rst;
  logic s0, s1, busy, done;
  logic [4:0] pos;
  logic f_s0, f_s1, f_busy, f_done;
  logic [4:0] f_pos;

  mod20_step_sequencer_if #(.LEN_W(LEN_W)) cmd_if ();
  mod20_step_sequencer_if #(.LEN_W(LEN_W)) fast_if ();

  mod20_step_sequencer #(.DIV(DIV), .LEN_W(LEN_W)) dut (
    .clk_50M(clk), .reset(rst), .cmd(cmd_if),
    .S0(s0), .S1(s1), .busy(busy), .done(done), .pos(pos)
  );

  mod20_step_sequencer #(.DIV(1), .LEN_W(LEN_W)) dut_fast (
    .clk_50M(clk), .reset(rst), .cmd(fast_if),
    .S0(f_s0), .S1(f_s1), .busy(f_busy), .done(f_done), .pos(f_pos)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int next_pos(input int p, input logic [1:0] m);
    case (m)
      UP:      return (p + 1) % 20;
      DOWN:    return (p + 19) % 20;
      CLEAR:   return 0;
      default: return p;
    endcase
  endfunction

  // Model state: commands accepted but not yet completed, oldest first.
  cmd_t q[$];
  cmd_t c_new;
  int   pos_m, cyc, pulses_cur, ticks_cur, busy_cyc, steps;
  int   total_pulses, total_done, last_done_cyc;
  int   pulse_log[$];
  bit   tick_now, prev_tick, prev_done;
  int   s_now;
  int   f_pulses, f_runs, f_done_cnt, f_other;
  bit   f_prev_up;

  initial begin
    total_pulses = 0; total_done = 0; last_done_cyc = 0;
    f_pulses = 0; f_runs = 0; f_done_cnt = 0; f_other = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        pos_m = 0; cyc = 0; pulses_cur = 0; ticks_cur = 0; busy_cyc = 0;
        prev_tick = 0; prev_done = 0; f_prev_up = 0;
      end else begin
        tick_now = ((cyc % DIV) == DIV - 1);
        s_now    = {s1, s0};
        check("pos", pos, pos_m);
        check("cmd_ready", cmd_if.cmd_ready, q.size() < 2);
        if (q.size() == 0) check("idle_busy", busy, 0);
        if (s_now != 0) begin
          total_pulses++;
          pulse_log.push_back(cyc);
          check("pulse_after_tick", prev_tick, 1);
          check("pulse_in_run", busy, 1);
          if (q.size() == 0) check("pulse_without_cmd", s_now, 0);
          else begin
            check("pin_code", s_now, q[0].mode);
            pulses_cur++;
            pos_m = next_pos(pos_m, q[0].mode);
          end
        end
        if (busy) begin
          busy_cyc++;
          if (tick_now) ticks_cur++;
        end
        if (done) begin
          total_done++;
          last_done_cyc = cyc;
          check("done_width", prev_done, 0);
          check("busy_in_fin", busy, 0);
          if (q.size() == 0) check("done_without_cmd", done, 0);
          else begin
            steps = (q[0].mode == CLEAR) ? 1 : q[0].len;
            check("pulse_count", pulses_cur, (q[0].mode == HOLD) ? 0 : steps);
            if (steps > 0) check("tick_count", ticks_cur, steps);
            else           check("len0_run_cycles", busy_cyc, 1);
            void'(q.pop_front());
            pulses_cur = 0; ticks_cur = 0; busy_cyc = 0;
          end
        end
        if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
          c_new.mode = cmd_if.cmd_mode;
          c_new.len  = int'(cmd_if.cmd_len);
          q.push_back(c_new);
        end
        prev_tick = tick_now;
        prev_done = done;
        cyc++;

        if ({f_s1, f_s0} == 2'b01) begin
          f_pulses++;
          if (!f_prev_up) f_runs++;
          f_prev_up = 1;
        end else begin
          f_prev_up = 0;
          if ({f_s1, f_s0} != 2'b00) f_other++;
        end
        if (f_done) f_done_cnt++;
      end
    end
  end

  task automatic send(input logic [1:0] m, input int l);
    int budget = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_mode  = m;
    cmd_if.cmd_len   = LEN_W'(l);
    @(negedge clk);
    while (!cmd_if.cmd_ready && budget < 2000) begin
      budget++;
      @(negedge clk);
    end
    if (!cmd_if.cmd_ready) check("send_timeout", cmd_if.cmd_ready, 1);
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 0;
    @(negedge clk);
    while ((q.size() != 0 || busy) && budget < 3000) begin
      budget++;
      @(negedge clk);
    end
    check("drain_timeout", q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic realign();
    @(posedge clk); #1;
  endtask

  initial begin
    int d0, p0, gap, len;
    logic [1:0] m;
    rst = 1'b1;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_mode = 2'd0; cmd_if.cmd_len = '0;
    fast_if.cmd_valid = 1'b0; fast_if.cmd_mode = 2'd0; fast_if.cmd_len = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset values and 100 idle cycles
    @(negedge clk);
    check("rst_S", {s1, s0}, 0);
    check("rst_pos", pos, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", cmd_if.cmd_ready, 1);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("idle_S", {s1, s0}, 0);
    check("idle_pos", pos, 0);
    check("idle_busy100", busy, 0);
    check("idle_ready", cmd_if.cmd_ready, 1);
    realign();

    // DIV=1 instance: UP 25 wraps and ends at 5
    f_pulses = 0; f_runs = 0; f_done_cnt = 0; f_other = 0;
    fast_if.cmd_valid = 1'b1; fast_if.cmd_mode = UP; fast_if.cmd_len = LEN_W'(25);
    realign();
    fast_if.cmd_valid = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("fast_pulses", f_pulses, 25);
    check("fast_contiguous", f_runs, 1);
    check("fast_other_codes", f_other, 0);
    check("fast_done", f_done_cnt, 1);
    check("fast_pos", f_pos, 5);
    check("fast_busy", f_busy, 0);
    realign();

    // bring pos to 2, then DOWN 3 at DIV=4
    send(CLEAR, 9);
    send(UP, 2);
    wait_idle();
    check("pos_setup2", pos, 2);
    pulse_log.delete();
    send(DOWN, 3);
    wait_idle();
    check("down_pos", pos, 19);
    check("down_pulses", pulse_log.size(), 3);
    if (pulse_log.size() == 3) begin
      check("down_gap1", pulse_log[1] - pulse_log[0], DIV);
      check("down_gap2", pulse_log[2] - pulse_log[1], DIV);
      check("down_done_lat", last_done_cyc - pulse_log[2], 2);
    end

    // UP len=0 then CLEAR back-to-back
    d0 = total_done; p0 = total_pulses;
    send(UP, 0);
    send(CLEAR, 200);
    wait_idle();
    check("len0_clear_pos", pos, 0);
    check("len0_clear_dones", total_done - d0, 2);
    check("len0_clear_pulses", total_pulses - p0, 1);

    // three commands with valid held: ready drops with two queued
    send(HOLD, 3);
    send(UP, 2);
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_mode = DOWN; cmd_if.cmd_len = LEN_W'(1);
    @(negedge clk);
    check("ready_full", cmd_if.cmd_ready, 0);
    realign();
    send(DOWN, 1);
    wait_idle();
    check("three_cmd_pos", pos, 1);

    // reset in the middle of a run with pos=7 and a pending command
    send(CLEAR, 0);
    send(UP, 7);
    wait_idle();
    check("pos_setup7", pos, 7);
    send(HOLD, 6);
    send(UP, 3);
    repeat (4) realign();
    @(negedge clk);
    check("busy_before_rst", busy, 1);
    realign();
    rst = 1'b1;
    realign();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_S", {s1, s0}, 0);
    check("midrst_pos", pos, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", cmd_if.cmd_ready, 1);
    realign();
    p0 = total_pulses;
    send(UP, 1);
    wait_idle();
    check("post_rst_pos", pos, 1);
    check("post_rst_pulses", total_pulses - p0, 1);

    // random command stream
    for (int i = 0; i < 40; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) realign();
      m   = 2'($urandom_range(0, 3));
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 30) : $urandom_range(0, 5);
      send(m, len);
    end
    wait_idle();
    check("random_final_pos", pos, pos_m);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish by %0t", $time);
    $fatal(1);
  end

endmodule
